nx_stream_distributor: RTL and testbench

Outbound counterpart of the node's inbound stream arbiter. Takes two message sources: the bypass stream (already carries a direction) and the node's own generated messages (carry a direction from the node core). Steers each accepted message into a per-direction output buffer that drives the north/east/south/west outbound links. Sits between the arbiter/node core and the mesh links in every node.

---
 rtl/nx_stream_distributor_pkg.sv | 25 ++
 rtl/nx_distributor_fifo.sv | 66 ++++++
 rtl/nx_stream_distributor.sv | 96 +++++++++
 tb/tb_nx_stream_distributor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nx_stream_distributor_pkg.sv
// Shared node types for the mesh datapath: message format, link directions
// and the source identifiers used by the outbound distributor's arbitration.
package NXConstants;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    EAST  = 2'd1,
    SOUTH = 2'd2,
    WEST  = 2'd3
  } direction_t;

  typedef struct packed {
    logic [3:0]  row;
    logic [3:0]  column;
    logic [23:0] payload;
  } node_message_t;

  typedef enum logic {
    SRC_BYPASS   = 1'b0,
    SRC_INTERNAL = 1'b1
  } source_t;

  localparam int NUM_DIRS = 4;

endpackage

// File: rtl/nx_distributor_fifo.sv
// Single-push/single-pop message FIFO for one outbound link. Space is judged
// on the registered count only, so a full FIFO never takes credit for a pop.
module nx_distributor_fifo
  import NXConstants::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  node_message_t push_data_i,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  output node_message_t pop_data_o,
  output logic          pop_valid_o,
  input  logic          pop_ready_i
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(OUT_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  node_message_t    mem_q [OUT_DEPTH];
  logic             push, pop;

  assign push_ready_o = (count_q < FULL_COUNT);
  assign pop_valid_o  = (count_q != '0);
  // Gating keeps the head at zero whenever empty, including straight after reset.
  assign pop_data_o   = pop_valid_o ? mem_q[rd_ptr_q] : '0;
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_valid_o && pop_ready_i;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/nx_stream_distributor.sv
// Outbound distributor: steers bypass and internally generated messages into
// per-link FIFOs, with a fairness pointer that alternates on same-link contention.
module nx_stream_distributor
  import NXConstants::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  node_message_t internal_data_i,
  input  direction_t    internal_dir_i,
  input  logic          internal_valid_i,
  output logic          internal_ready_o,
  input  node_message_t bypass_data_i,
  input  direction_t    bypass_dir_i,
  input  logic          bypass_valid_i,
  output logic          bypass_ready_o,
  output node_message_t north_data_o,
  output node_message_t east_data_o,
  output node_message_t south_data_o,
  output node_message_t west_data_o,
  output logic          north_valid_o,
  output logic          east_valid_o,
  output logic          south_valid_o,
  output logic          west_valid_o,
  input  logic          north_ready_i,
  input  logic          east_ready_i,
  input  logic          south_ready_i,
  input  logic          west_ready_i,
  output logic          idle_o
);

  source_t             prio_q, prio_d;
  logic [NUM_DIRS-1:0] space;
  logic [NUM_DIRS-1:0] fifo_valid;
  logic [NUM_DIRS-1:0] fifo_ready;
  node_message_t       fifo_data [NUM_DIRS];
  logic                int_elig, byp_elig, contention;
  logic                int_grant, byp_grant;

  always_comb begin
    int_elig   = internal_valid_i && space[internal_dir_i];
    byp_elig   = bypass_valid_i && space[bypass_dir_i];
    contention = int_elig && byp_elig && (internal_dir_i == bypass_dir_i);
    int_grant  = int_elig && (!contention || (prio_q == SRC_INTERNAL));
    byp_grant  = byp_elig && (!contention || (prio_q == SRC_BYPASS));
    // The loser of a contention cycle owns the next one.
    prio_d     = prio_q;
    if (contention) prio_d = int_grant ? SRC_BYPASS : SRC_INTERNAL;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prio_q <= SRC_BYPASS;
    else       prio_q <= prio_d;
  end

  assign internal_ready_o = int_grant;
  assign bypass_ready_o   = byp_grant;

  assign fifo_ready = {west_ready_i, south_ready_i, east_ready_i, north_ready_i};

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_link
    logic          byp_hit, int_hit;
    node_message_t push_data;

    // Both grants never land on the same link, so the select is unambiguous.
    assign byp_hit   = byp_grant && (bypass_dir_i == direction_t'(d));
    assign int_hit   = int_grant && (internal_dir_i == direction_t'(d));
    assign push_data = byp_hit ? bypass_data_i : internal_data_i;

    nx_distributor_fifo #(
      .OUT_DEPTH (OUT_DEPTH)
    ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_data_i  (push_data),
      .push_valid_i (byp_hit || int_hit),
      .push_ready_o (space[d]),
      .pop_data_o   (fifo_data[d]),
      .pop_valid_o  (fifo_valid[d]),
      .pop_ready_i  (fifo_ready[d])
    );
  end

  assign north_data_o  = fifo_data[NORTH];
  assign east_data_o   = fifo_data[EAST];
  assign south_data_o  = fifo_data[SOUTH];
  assign west_data_o   = fifo_data[WEST];
  assign north_valid_o = fifo_valid[NORTH];
  assign east_valid_o  = fifo_valid[EAST];
  assign south_valid_o = fifo_valid[SOUTH];
  assign west_valid_o  = fifo_valid[WEST];

  assign idle_o = (fifo_valid == '0) && !internal_valid_i && !bypass_valid_i;

endmodule

// File: tb/tb_nx_stream_distributor.sv
// Self-checking bench for nx_stream_distributor: grant table, hand-written
// stall/reset sequences and a randomized run against a queue-based model.
module tb_nx_stream_distributor;
  import NXConstants::*;

  localparam int OUT_DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  node_message_t internal_data_i, bypass_data_i;
  direction_t    internal_dir_i, bypass_dir_i;
  logic          internal_valid_i, bypass_valid_i;
  logic          internal_ready_o, bypass_ready_o;
  node_message_t north_data_o, east_data_o, south_data_o, west_data_o;
  logic          north_valid_o, east_valid_o, south_valid_o, west_valid_o;
  logic          north_ready_i, east_ready_i, south_ready_i, west_ready_i;
  logic          idle_o;

  always #5 clk = ~clk;

  nx_stream_distributor #(.OUT_DEPTH(OUT_DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .internal_data_i  (internal_data_i),
    .internal_dir_i   (internal_dir_i),
    .internal_valid_i (internal_valid_i),
    .internal_ready_o (internal_ready_o),
    .bypass_data_i    (bypass_data_i),
    .bypass_dir_i     (bypass_dir_i),
    .bypass_valid_i   (bypass_valid_i),
    .bypass_ready_o   (bypass_ready_o),
    .north_data_o     (north_data_o),
    .east_data_o      (east_data_o),
    .south_data_o     (south_data_o),
    .west_data_o      (west_data_o),
    .north_valid_o    (north_valid_o),
    .east_valid_o     (east_valid_o),
    .south_valid_o    (south_valid_o),
    .west_valid_o     (west_valid_o),
    .north_ready_i    (north_ready_i),
    .east_ready_i     (east_ready_i),
    .south_ready_i    (south_ready_i),
    .west_ready_i     (west_ready_i),
    .idle_o           (idle_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic logic [3:0] dut_valid();
    return {west_valid_o, south_valid_o, east_valid_o, north_valid_o};
  endfunction

  function automatic logic [31:0] dut_data(input int d);
    case (d)
      0:       return north_data_o;
      1:       return east_data_o;
      2:       return south_data_o;
      default: return west_data_o;
    endcase
  endfunction

  // Reference model: one queue per link plus the "who wins next tie" source.
  node_message_t mq [NUM_DIRS][$];
  source_t       m_prio;
  logic          m_ig, m_bg;
  logic          got_ir, got_br;
  logic          hold_i, hold_b;

  function automatic void model_reset();
    for (int d = 0; d < NUM_DIRS; d++) mq[d].delete();
    m_prio = SRC_BYPASS;
    hold_i = 1'b0;
    hold_b = 1'b0;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic tick(input logic iv, input direction_t id, input logic bv,
                      input direction_t bd, input logic [3:0] rdy);
    logic [3:0] sp, exp_v;
    logic       ie, be, all_empty;
    if (!hold_i) internal_data_i = node_message_t'($urandom);
    if (!hold_b) bypass_data_i   = node_message_t'($urandom);
    internal_valid_i = iv;
    internal_dir_i   = id;
    bypass_valid_i   = bv;
    bypass_dir_i     = bd;
    {west_ready_i, south_ready_i, east_ready_i, north_ready_i} = rdy;
    #2;
    all_empty = 1'b1;
    for (int d = 0; d < NUM_DIRS; d++) begin
      sp[d]    = mq[d].size() < OUT_DEPTH;
      exp_v[d] = mq[d].size() != 0;
      if (exp_v[d]) all_empty = 1'b0;
    end
    ie = iv && sp[id];
    be = bv && sp[bd];
    if (ie && be && (id == bd)) begin
      m_ig   = (m_prio == SRC_INTERNAL);
      m_bg   = !m_ig;
      m_prio = m_ig ? SRC_BYPASS : SRC_INTERNAL;
    end else begin
      m_ig = ie;
      m_bg = be;
    end
    got_ir = internal_ready_o;
    got_br = bypass_ready_o;
    check("ready{int,byp}", {30'd0, got_ir, got_br}, {30'd0, m_ig, m_bg});
    check("valid[W:N]", {28'd0, dut_valid()}, {28'd0, exp_v});
    for (int d = 0; d < NUM_DIRS; d++)
      if (exp_v[d]) check($sformatf("data_dir%0d", d), dut_data(d), mq[d][0]);
    check("idle", {31'd0, idle_o}, {31'd0, all_empty && !iv && !bv});
    @(posedge clk);
    #1;
    for (int d = 0; d < NUM_DIRS; d++)
      if (exp_v[d] && rdy[d]) void'(mq[d].pop_front());
    if (m_bg) mq[bd].push_back(bypass_data_i);
    if (m_ig) mq[id].push_back(internal_data_i);
    hold_i = iv && !m_ig;
    hold_b = bv && !m_bg;
  endtask

  typedef struct {
    logic       iv;
    direction_t id;
    logic       bv;
    direction_t bd;
    logic       ir;
    logic       br;
  } vec_t;

  vec_t       vecs [9];
  direction_t cur_id, cur_bd;
  logic       cur_iv, cur_bv;

  initial begin
    // Grant table from reset with every link draining each cycle.
    vecs[0] = '{1'b0, NORTH, 1'b1, EAST,  1'b0, 1'b1};
    vecs[1] = '{1'b1, NORTH, 1'b1, SOUTH, 1'b1, 1'b1};
    vecs[2] = '{1'b1, WEST,  1'b1, WEST,  1'b0, 1'b1};
    vecs[3] = '{1'b1, WEST,  1'b1, WEST,  1'b1, 1'b0};
    vecs[4] = '{1'b1, WEST,  1'b1, WEST,  1'b0, 1'b1};
    vecs[5] = '{1'b1, WEST,  1'b1, WEST,  1'b1, 1'b0};
    vecs[6] = '{1'b1, NORTH, 1'b1, WEST,  1'b1, 1'b1};
    vecs[7] = '{1'b1, WEST,  1'b1, WEST,  1'b0, 1'b1};
    vecs[8] = '{1'b1, WEST,  1'b0, NORTH, 1'b1, 1'b0};

    rst_i            = 1'b1;
    internal_valid_i = 1'b0;
    bypass_valid_i   = 1'b0;
    internal_dir_i   = NORTH;
    bypass_dir_i     = NORTH;
    internal_data_i  = '0;
    bypass_data_i    = '0;
    {west_ready_i, south_ready_i, east_ready_i, north_ready_i} = 4'hF;
    model_reset();
    #2;
    check("reset_valid", {28'd0, dut_valid()}, 32'd0);
    for (int d = 0; d < NUM_DIRS; d++) check($sformatf("reset_data_dir%0d", d), dut_data(d), 32'd0);
    check("reset_idle", {31'd0, idle_o}, 32'd1);
    check("reset_ready", {30'd0, internal_ready_o, bypass_ready_o}, 32'd0);
    #10 rst_i = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].iv, vecs[i].id, vecs[i].bv, vecs[i].bd, 4'hF);
      check($sformatf("vec%0d_ready", i), {30'd0, got_ir, got_br}, {30'd0, vecs[i].ir, vecs[i].br});
    end
    tick(1'b0, NORTH, 1'b0, NORTH, 4'hF);
    tick(1'b0, NORTH, 1'b0, NORTH, 4'hF);

    // West blocked: bypass fills it and then stalls while internal keeps flowing east.
    tick(1'b1, EAST, 1'b1, WEST, 4'b0111);
    tick(1'b1, EAST, 1'b1, WEST, 4'b0111);
    tick(1'b1, EAST, 1'b1, WEST, 4'b0111);
    check("full_west_byp_stall", {31'd0, got_br}, 32'd0);
    check("full_west_int_flows", {31'd0, got_ir}, 32'd1);
    tick(1'b0, EAST, 1'b1, WEST, 4'hF);
    check("full_no_pop_credit", {31'd0, got_br}, 32'd0);
    tick(1'b0, EAST, 1'b1, WEST, 4'hF);
    check("after_pop_accept", {31'd0, got_br}, 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b0, NORTH, 1'b0, NORTH, 4'hF);

    // Fill north, then reset in the middle of a cycle.
    tick(1'b1, NORTH, 1'b0, NORTH, 4'b1110);
    tick(1'b1, NORTH, 1'b0, NORTH, 4'b1110);
    check("north_filled", {31'd0, north_valid_o}, 32'd1);
    internal_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_north_valid", {31'd0, north_valid_o}, 32'd0);
    check("async_rst_north_data", north_data_o, 32'd0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", {31'd0, idle_o}, 32'd1);
    tick(1'b1, SOUTH, 1'b0, NORTH, 4'hF);
    check("single_after_reset", {28'd0, dut_valid()}, 32'd4);
    tick(1'b0, NORTH, 1'b0, NORTH, 4'hF);

    // Randomized traffic; held requests keep valid, dir and data.
    cur_iv = 1'b0;
    cur_bv = 1'b0;
    cur_id = NORTH;
    cur_bd = NORTH;
    for (int i = 0; i < 600; i++) begin
      if (!hold_i) begin
        cur_iv = ($urandom_range(0, 99) < 60);
        cur_id = direction_t'($urandom_range(0, 3));
      end
      if (!hold_b) begin
        cur_bv = ($urandom_range(0, 99) < 60);
        cur_bd = direction_t'($urandom_range(0, 3));
      end
      tick(cur_iv, cur_id, cur_bv, cur_bd, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
